// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between load/store sizing and the data-memory controller.
// Latency: none (wires only); the controller defines all timing.
// Backpressure: req_valid is held by the master until req_ready; no response-side stall.
// Optional misalign_err wire exists only when MISALIGN_TRAP_EN is defined.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;

  // Upstream side: issues requests, observes completion and trap flag
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask,
    input  req_ready, rsp_valid, rsp_rdata, busy, misalign_err
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask,
    output req_ready, rsp_valid, rsp_rdata, busy, misalign_err
  );
`else
  // Upstream side: issues requests, observes completion
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
`endif
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: one masked store or full-word load at a time.
// Latency: accept in cycle 0 -> rsp_valid pulse in cycle LATENCY+1; next accept in LATENCY+2.
// Backpressure: req_ready low whenever not IDLE or in reset; requests seen while busy are dropped.
// Optional feature: MISALIGN_TRAP_EN adds misalign_err and suppresses illegal mask/address accesses.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Counter only ever holds LATENCY-1 down to 0
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            commit;

  // Latched request
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      mask_q;

  logic [31:0]     rdata_q;
  logic            legal;

  logic [31:0]     mem_q [DEPTH_WORDS];

  // Upper address bits select nothing: the array wraps modulo DEPTH_WORDS*4
  logic            unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

  assign bus.req_ready = (state_q == IDLE) & ~rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP) & ~rst;
  assign bus.rsp_rdata = rdata_q;

`ifdef MISALIGN_TRAP_EN
  logic [1:0] lo_q;
  logic       err_q;

  // Legal: full word aligned, halfword on even byte, or any single byte
  always_comb begin
    legal = 1'b0;
    if (mask_q == 4'b1111 && lo_q == 2'b00) begin
      legal = 1'b1;
    end else if ((mask_q == 4'b0011 || mask_q == 4'b1100) && !lo_q[0]) begin
      legal = 1'b1;
    end else if (mask_q == 4'b0001 || mask_q == 4'b0010 ||
                 mask_q == 4'b0100 || mask_q == 4'b1000) begin
      legal = 1'b1;
    end
  end

  assign bus.misalign_err = err_q & (state_q == RESP) & ~rst;

  // Byte offset and trap flag, captured with the request and at commit respectively
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q  <= 2'b00;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        lo_q <= bus.req_addr[1:0];
      end
      if (commit) begin
        err_q <= ~legal;
      end
    end
  end
`else
  // Without the trap every mask is applied exactly as given
  assign legal = 1'b1;
`endif

  // Next-state logic: IDLE -> WAIT (count down) -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept  = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && !we_q && legal) begin
        rdata_q <= mem_q[idx_q];
      end
    end
  end

  // Request capture; held constant through WAIT so the commit sees a stable request
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      idx_q   <= bus.req_addr[AW+1:2];
      wdata_q <= bus.req_wdata;
      mask_q  <= bus.req_mask;
    end
  end

  // Masked byte-lane write; the array itself is never reset
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q && legal) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
